// File: rtl/get_controller.sv
// Purpose: consumer-side FIFO read controller with a 2-entry skid buffer.
// Latency: en_get in cycle N, word visible on data_out in N+2; one word/cycle sustained.
// Backpressure: reads only while buffer space (held + in flight) is reserved; req_get=0 stalls after 2 strobes.
module get_controller #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  empty,
    output logic                  en_get,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  req_get,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [1:0]            cnt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic                  pop;
    logic [1:0]            reserved;

    assign valid_out = (cnt != 2'd0);
    assign data_out  = head_q;
    assign pop       = valid_out && req_get;
    assign reserved  = cnt + {1'b0, inflight};

    // A pop this cycle frees a slot, so a full buffer can be refilled without a bubble.
    assign en_get = !rst && !empty && ((reserved - {1'b0, pop}) < 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 2'd0;
            inflight <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            inflight <= en_get;

            if (inflight) begin
                if (cnt == 2'd0 || (cnt == 2'd1 && pop)) begin
                    head_q <= fifo_data;
                end else if (cnt == 2'd1) begin
                    tail_q <= fifo_data;
                end else if (pop) begin
                    head_q <= tail_q;
                    tail_q <= fifo_data;
                end
            end else if (pop && cnt == 2'd2) begin
                head_q <= tail_q;
            end

            if (inflight && !pop) begin
                cnt <= cnt + 2'd1;
            end else if (!inflight && pop) begin
                cnt <= cnt - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_get_controller.sv
// Bench for get_controller: queue-based FIFO model plus a scoreboard of words read but not yet consumed.
module tb_get_controller;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          empty;
    logic          en_get;
    logic [DW-1:0] fifo_data;
    logic          req_get;
    logic          valid_out;
    logic [DW-1:0] data_out;

    always #5 clk = ~clk;

    get_controller #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .en_get    (en_get),
        .fifo_data (fifo_data),
        .req_get   (req_get),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    typedef struct {
        logic [DW-1:0] d;
        int            issue;
    } ent_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            chk_on = 1'b0;
    bit            prev_rst = 1'b0;
    logic [DW-1:0] fifo_q[$];
    ent_t          exp_q[$];
    bit            pend_vld = 1'b0;
    logic [DW-1:0] pend_dat;
    int            n_en = 0;
    int            n_deliv = 0;
    int            first_deliv = 0;
    int            last_deliv = 0;
    int            rel_cyc = 0;

    // A word read in cycle N is presentable from cycle N+2 onward.
    function automatic bit model_valid();
        return (exp_q.size() > 0) && ((cyc - exp_q[0].issue) >= 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_en    = 0;
        n_deliv = 0;
    endtask

    task automatic step(input bit r, input bit q);
        bit mpop;
        bit exp_en;
        int sz;
        @(negedge clk);
        cyc++;
        rst       = r;
        req_get   = q;
        fifo_data = pend_vld ? pend_dat : DW'($urandom);
        pend_vld  = 1'b0;
        empty     = (fifo_q.size() == 0);
        #1;
        sz     = exp_q.size();
        mpop   = model_valid() && q;
        exp_en = !r && !empty && ((sz - int'(mpop)) < 2);
        if (chk_on) check("en_get", en_get, exp_en);
        if (en_get === 1'b1 && fifo_q.size() > 0) begin
            pend_dat = fifo_q.pop_front();
            pend_vld = 1'b1;
            exp_q.push_back('{pend_dat, cyc});
            n_en++;
        end
        if (r) pend_vld = 1'b0;
    endtask

    // Monitor: compares presented output against the scoreboard head and retires consumed words.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (chk_on) begin
                check("valid_out", valid_out, model_valid());
                if (model_valid()) check("data_out", data_out, exp_q[0].d);
                if (prev_rst) check("data_out_reset", data_out, 0);
            end
            if (rst) begin
                exp_q.delete();
            end else if (model_valid() && req_get) begin
                void'(exp_q.pop_front());
                if (n_deliv == 0) first_deliv = cyc;
                last_deliv = cyc;
                n_deliv++;
            end
            prev_rst = rst;
        end
    end

    initial begin
        rst       = 1'b1;
        req_get   = 1'b0;
        empty     = 1'b1;
        fifo_data = '0;

        step(1'b1, 1'b0);
        chk_on = 1'b1;

        // Reset held with a non-empty FIFO and an eager consumer, then a single word.
        fifo_q.push_back(8'hA5);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        clear_counts();
        rel_cyc = cyc + 1;
        repeat (5) step(1'b0, 1'b1);
        check("single_count", n_deliv, 1);
        check("single_latency", first_deliv - rel_cyc, 2);

        // Streaming 16 words.
        clear_counts();
        for (int i = 1; i <= 16; i++) fifo_q.push_back(DW'(i));
        repeat (20) step(1'b0, 1'b1);
        check("stream_en_count", n_en, 16);
        check("stream_deliv", n_deliv, 16);
        check("stream_gapless", last_deliv - first_deliv, 15);

        // Backpressure then resume.
        clear_counts();
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
        repeat (8) step(1'b0, 1'b0);
        check("bp_en_count", n_en, 2);
        check("bp_valid", valid_out, 1);
        check("bp_data", data_out, 8'h01);
        repeat (14) step(1'b0, 1'b1);
        check("bp_deliv", n_deliv, 8);
        check("bp_gapless", last_deliv - first_deliv, 7);
        check("bp_en_total", n_en, 8);

        // Empty boundary with a random consumer afterwards.
        clear_counts();
        fifo_q.push_back(8'h3C);
        repeat (5) step(1'b0, 1'b1);
        repeat (20) step(1'b0, 1'($urandom_range(0, 1)));
        check("empty_deliv", n_deliv, 1);
        check("empty_en_count", n_en, 1);

        // Reset while one word is held and another is in flight.
        clear_counts();
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(8'h50 + i));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        fifo_q.delete();
        step(1'b0, 1'b1);
        check("midrst_valid", valid_out, 0);
        repeat (5) step(1'b0, 1'b1);
        check("midrst_deliv", n_deliv, 0);

        // Random traffic with occasional resets.
        clear_counts();
        repeat (400) begin
            if ($urandom_range(0, 2) == 0) fifo_q.push_back(DW'($urandom));
            if ($urandom_range(0, 96) == 0) begin
                step(1'b1, 1'($urandom_range(0, 1)));
                fifo_q.delete();
            end else begin
                step(1'b0, ($urandom_range(0, 3) != 0));
            end
        end
        repeat (12) step(1'b0, 1'b1);
        check("drain_scoreboard", exp_q.size(), 0);
        check("drain_valid", valid_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
